imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, memory word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 128, number of memory words.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clock, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle load request.
REQ-007 SHALL have port word_count, input, 32, number of words to load, sampled with start.
REQ-008 SHALL have port byte_valid, input, 1, byte stream valid.
REQ-009 SHALL have port byte_data, input, 8, byte stream payload.
REQ-010 SHALL have port byte_ready, output, 1, byte accepted when byte_valid and byte_ready are both 1.
REQ-011 SHALL have memory write-side ports data (output, WIDTH, write data), wraddress (output, 32, write address) and wren (output, 1, write enable).
REQ-012 SHALL have memory read-side ports rdaddress (output, 32, read address), rden (output, 1, read enable) and q (input, WIDTH, read data, valid one cycle after rden).
REQ-013 SHALL have status outputs busy (1), done (1), error (1) and cpu_hold (1); cpu_hold holds the pipeline.

Function
REQ-014 SHALL implement the states IDLE, COLLECT, WRITE, VERIFY and FINISH.
REQ-015 In IDLE: start=1 with word_count=0 -> FINISH, error=0; otherwise latch count = min(word_count, DEPTH), clear address/checksums -> COLLECT.
REQ-016 SHALL ignore start in COLLECT, WRITE and VERIFY; in FINISH, start re-enters per REQ-015.
REQ-017 byte_ready SHALL be 1 only in COLLECT.
REQ-018 Each accepted byte SHALL fill lane byte_idx, little-endian (first byte -> bits 7:0).
REQ-019 After accepting the (WIDTH/8)th byte, the FSM SHALL move to WRITE next cycle, with byte_idx wrapping to 0.
REQ-020 WRITE SHALL last exactly one cycle: wren=1, wraddress=waddr, data=assembled word; wr_sum ^= word.
REQ-021 After WRITE, waddr SHALL increment; if waddr was count-1 -> VERIFY, else -> COLLECT.
REQ-022 VERIFY SHALL assert rden=1 with rdaddress = 0..count-1, one address per cycle, back-to-back.
REQ-023 A one-cycle delayed valid SHALL qualify q; rd_sum ^= q for each returned word.
REQ-024 VERIFY SHALL exit to FINISH on the cycle after the last q is captured; error = (rd_sum != wr_sum).
REQ-025 In FINISH: done=1, busy=0, cpu_hold=0; error SHALL hold until the next start or reset.
REQ-026 busy SHALL be 1 in COLLECT, WRITE and VERIFY; cpu_hold SHALL be 1 in every state except FINISH.
REQ-027 wren and rden SHALL never be asserted in the same cycle; wren and rden SHALL be 0 in all states other than those specified.
REQ-028 Addresses SHALL use log2(DEPTH) significant bits, zero-extended to 32.
REQ-029 A byte_valid that drops mid-word SHALL stall assembly without losing accepted lanes.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE.
REQ-031 reset_n=0 SHALL clear byte_idx, waddr, raddr, count, wr_sum, rd_sum, the assembled word and the delayed valid.
REQ-032 Reset output values SHALL be: byte_ready=0, wren=0, rden=0, data=0, wraddress=0, rdaddress=0, busy=0, done=0, error=0, cpu_hold=1.
REQ-033 Reset mid-load SHALL abandon the load; memory contents already written are not restored.

Structure
REQ-034 The state encoding, BYTES_PER_WORD and the address-width function SHALL reside in shared package loader_pkg.
REQ-035 Byte-to-word assembly SHALL be one sub-module, word_assembler (lane counter plus shift register, outputs word and word_valid).

Verification
REQ-036 Bench SHALL check: after reset, cpu_hold=1, done=0, byte_ready=0, and no wren/rden pulses.
REQ-037 Bench SHALL check: start, count=2, bytes 03 22 30 00 83 20 10 00 -> mem[0]=0x00302203, mem[1]=0x00102083, done=1, error=0, cpu_hold=0.
REQ-038 Bench SHALL check: the same stream with byte_valid gapped 3 cycles between bytes -> identical memory contents; exactly 2 wren pulses.
REQ-039 Bench SHALL check: testbench forces mem[1]=0 after its write and before VERIFY -> error=1, done=1.
REQ-040 Bench SHALL check: start with count=0 -> done=1 next cycle, no wren; start with count=200 -> exactly 128 writes, last wraddress=127.
REQ-041 Bench SHALL check: reset_n pulsed low after 5 of 8 bytes -> IDLE, cpu_hold=1; a fresh start reloads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding and sizing helpers for the imem loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_COLLECT = 3'd1;
    localparam state_t S_WRITE   = 3'd2;
    localparam state_t S_VERIFY  = 3'd3;
    localparam state_t S_FINISH  = 3'd4;

    localparam int BYTES_PER_WORD = 4;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    // Never narrower than one bit, so a single-entry space still has an index.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ============================================================================
// Module   : word_assembler
// Brief    : Packs accepted bytes little-endian into one memory word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_assembler
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_accept,
    input  logic [7:0]       i_byte_data,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_valid,
    output logic             o_lane_last
);

    localparam int C_BPW       = bytes_per_word(WIDTH);
    localparam int C_LANE_W    = addr_bits(C_BPW);
    localparam logic [C_LANE_W-1:0] C_LAST_LANE = C_LANE_W'(C_BPW - 1);

    logic [C_LANE_W-1:0] r_lane;
    logic [WIDTH-1:0]    r_word;
    logic                r_word_valid;
    logic [WIDTH-1:0]    w_shifted;
    logic                w_lane_last;

    // Bytes enter at the top and shift down, so the first byte lands in 7:0.
    generate
        if (WIDTH == 8) begin : g_single_lane
            assign w_shifted = i_byte_data;
        end else begin : g_multi_lane
            assign w_shifted = {i_byte_data, r_word[WIDTH-1:8]};
        end
    endgenerate

    assign w_lane_last = (r_lane == C_LAST_LANE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane       <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_accept && w_lane_last;
            if (i_clear) begin
                r_lane <= '0;
                r_word <= '0;
            end else if (i_accept) begin
                r_word <= w_shifted;
                r_lane <= w_lane_last ? '0 : r_lane + C_LANE_W'(1);
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_lane_last  = w_lane_last;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a byte stream into instruction memory, then verifies it by
//            comparing write-side and read-back XOR checksums.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import loader_pkg::*;
#(
    parameter int WIDTH = 8 * BYTES_PER_WORD,
    parameter int DEPTH = 128
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [WIDTH-1:0] data,
    output logic [31:0]      wraddress,
    output logic             wren,
    output logic [31:0]      rdaddress,
    output logic             rden,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);

    localparam int C_ADDR_W  = addr_bits(DEPTH);
    localparam int C_COUNT_W = C_ADDR_W + 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [C_COUNT_W-1:0]   r_count;
    logic [C_ADDR_W-1:0]    r_waddr;
    logic [C_COUNT_W-1:0]   r_raddr;
    logic [WIDTH-1:0]       r_wr_sum;
    logic [WIDTH-1:0]       r_rd_sum;
    logic                   r_rd_pend;
    logic                   r_error;

    logic                   w_accept;
    logic                   w_start_load;
    logic                   w_zero_count;
    logic [C_COUNT_W-1:0]   w_load_count;
    logic                   w_last_word;
    logic                   w_rd_issued;
    logic [WIDTH-1:0]       w_word;
    logic                   w_word_valid;
    logic                   w_lane_last;

    assign w_accept     = byte_valid && byte_ready;
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_FINISH));
    assign w_zero_count = (word_count == 32'd0);
    assign w_load_count = (word_count > 32'(DEPTH)) ? C_COUNT_W'(DEPTH)
                                                     : word_count[C_COUNT_W-1:0];
    assign w_last_word  = ({1'b0, r_waddr} == (r_count - C_COUNT_W'(1)));
    assign w_rd_issued  = (r_raddr == r_count);

    word_assembler #(
        .WIDTH (WIDTH)
    ) u_word_assembler (
        .clk          (clock),
        .rst_n        (reset_n),
        .i_clear      (w_start_load),
        .i_accept     (w_accept),
        .i_byte_data  (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_lane_last  (w_lane_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    w_next = w_zero_count ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept && w_lane_last) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_word ? S_VERIFY : S_COLLECT;
            end
            // Leave only once every read is issued and its data folded in.
            S_VERIFY: begin
                if (w_rd_issued && !r_rd_pend) begin
                    w_next = S_FINISH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        wren       = 1'b0;
        rden       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        data       = '0;
        wraddress  = '0;
        rdaddress  = '0;
        error      = r_error;
        case (r_state)
            S_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                busy      = 1'b1;
                wren      = 1'b1;
                data      = w_word;
                wraddress = {{(32-C_ADDR_W){1'b0}}, r_waddr};
            end
            S_VERIFY: begin
                busy = 1'b1;
                if (!w_rd_issued) begin
                    rden      = 1'b1;
                    rdaddress = {{(32-C_ADDR_W){1'b0}}, r_raddr[C_ADDR_W-1:0]};
                end
            end
            S_FINISH: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            default: begin
                cpu_hold = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_wr_sum  <= '0;
            r_rd_sum  <= '0;
            r_rd_pend <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_rd_pend <= rden;
            if (w_start_load) begin
                r_count  <= w_load_count;
                r_waddr  <= '0;
                r_raddr  <= '0;
                r_wr_sum <= '0;
                r_rd_sum <= '0;
                r_error  <= 1'b0;
            end else begin
                if (wren) begin
                    r_waddr <= r_waddr + C_ADDR_W'(1);
                end
                if (w_word_valid) begin
                    r_wr_sum <= r_wr_sum ^ w_word;
                end
                if (rden) begin
                    r_raddr <= r_raddr + C_COUNT_W'(1);
                end
                if (r_rd_pend) begin
                    r_rd_sum <= r_rd_sum ^ q;
                end
                if ((r_state == S_VERIFY) && (w_next == S_FINISH)) begin
                    r_error <= (r_rd_sum != r_wr_sum);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader with a behavioural memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] data;
    logic [31:0] wraddress;
    logic        wren;
    logic [31:0] rdaddress;
    logic        rden;
    logic [31:0] q;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [7:0]  stim[$];
    logic [31:0] mem[128];
    logic        mem_clr;
    logic        corrupt_en;
    logic        corrupt_pending;
    int          n_checks;
    int          n_errors;
    int          wr_pulses;
    int          rd_pulses;
    logic [31:0] last_wraddr;

    imem_loader #(
        .WIDTH (32),
        .DEPTH (128)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .data       (data),
        .wraddress  (wraddress),
        .wren       (wren),
        .rdaddress  (rdaddress),
        .rden       (rden),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model; optionally zeroes mem[1] the cycle after it is written.
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
            corrupt_pending <= 1'b0;
        end else begin
            if (wren) mem[wraddress[6:0]] <= data;
            if (corrupt_pending) mem[1] <= 32'd0;
            corrupt_pending <= wren && corrupt_en && (wraddress == 32'd1);
        end
        if (rden) q <= mem[rdaddress[6:0]];
    end

    always @(negedge clock) begin
        if (reset_n && wren) begin
            wr_pulses++;
            last_wraddr = wraddress;
            chk("wr_rd_excl", {63'd0, rden}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("wr_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {32'd0, wraddress}, {32'd0, e.addr});
                chk("wr_data", {32'd0, data}, {32'd0, e.data});
            end
        end
        if (reset_n && rden) rd_pulses++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic push_expected(input int cnt);
        int n;
        wr_t w;
        n = (cnt > 128) ? 128 : cnt;
        for (int i = 0; i < n; i++) begin
            w.addr = 32'(i);
            w.data = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            exp_q.push_back(w);
        end
    endtask

    task automatic send_bytes(input int first, input int nbytes, input int gap);
        int waitc;
        for (int i = first; i < first + nbytes; i++) begin
            byte_valid = 1'b1;
            byte_data  = stim[i];
            waitc = 0;
            while (!byte_ready && waitc < 50) begin
                tick();
                waitc++;
            end
            if (!byte_ready) begin
                chk("ready_timeout", 64'd0, 64'd1);
                byte_valid = 1'b0;
                return;
            end
            tick();
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic begin_load(input int cnt);
        wr_pulses  = 0;
        start      = 1'b1;
        word_count = 32'(cnt);
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input int cnt, input int gap, input int nbytes);
        int n;
        push_expected(cnt);
        begin_load(cnt);
        @(negedge clock);
        chk("load_busy", {63'd0, busy}, 64'd1);
        chk("load_hold", {63'd0, cpu_hold}, 64'd1);
        tick();
        send_bytes(0, nbytes, gap);
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        @(negedge clock);
    endtask

    task automatic load_basic_stim();
        stim.delete();
        stim = '{8'h03, 8'h22, 8'h30, 8'h00, 8'h83, 8'h20, 8'h10, 8'h00};
    endtask

    initial begin
        n_checks = 0;   n_errors = 0;
        wr_pulses = 0;  rd_pulses = 0;
        reset_n = 1'b1; start = 1'b0; word_count = 32'd0;
        byte_valid = 1'b0; byte_data = 8'd0;
        mem_clr = 1'b0; corrupt_en = 1'b0; corrupt_pending = 1'b0;
        q = 32'd0; last_wraddr = 32'd0;
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        wr_pulses = 0; rd_pulses = 0;
        clear_mem();
        repeat (4) tick();
        @(negedge clock);
        chk("rst_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_wren_pulses", 64'(wr_pulses), 64'd0);
        chk("rst_rden_pulses", 64'(rd_pulses), 64'd0);

        // Basic two-word load
        load_basic_stim();
        run_load(2, 0, 8);
        chk("basic_mem0", {32'd0, mem[0]}, 64'h0030_2203);
        chk("basic_mem1", {32'd0, mem[1]}, 64'h0010_2083);
        chk("basic_done", {63'd0, done}, 64'd1);
        chk("basic_error", {63'd0, error}, 64'd0);
        chk("basic_hold", {63'd0, cpu_hold}, 64'd0);
        chk("basic_wr_count", 64'(wr_pulses), 64'd2);

        // Same stream with 3-cycle gaps between bytes
        clear_mem();
        run_load(2, 3, 8);
        chk("gap_mem0", {32'd0, mem[0]}, 64'h0030_2203);
        chk("gap_mem1", {32'd0, mem[1]}, 64'h0010_2083);
        chk("gap_wr_count", 64'(wr_pulses), 64'd2);
        chk("gap_error", {63'd0, error}, 64'd0);

        // Memory corrupted between write and verify
        clear_mem();
        corrupt_en = 1'b1;
        run_load(2, 0, 8);
        corrupt_en = 1'b0;
        chk("corrupt_error", {63'd0, error}, 64'd1);
        chk("corrupt_done", {63'd0, done}, 64'd1);
        repeat (3) tick();
        chk("corrupt_error_hold", {63'd0, error}, 64'd1);

        // Zero-count start from FINISH clears error
        begin_load(0);
        chk("zero_clr_error", {63'd0, error}, 64'd0);
        chk("zero_clr_done", {63'd0, done}, 64'd1);

        // Zero-count start from IDLE
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("zero_idle_done", {63'd0, done}, 64'd0);
        begin_load(0);
        chk("zero_done_next", {63'd0, done}, 64'd1);
        repeat (3) tick();
        chk("zero_wr_count", 64'(wr_pulses), 64'd0);

        // Oversized count is clamped to DEPTH
        clear_mem();
        stim.delete();
        for (int k = 0; k < 512; k++) stim.push_back(8'(k * 13 + 5));
        run_load(200, 0, 512);
        chk("big_wr_count", 64'(wr_pulses), 64'd128);
        chk("big_last_addr", {32'd0, last_wraddr}, 64'd127);
        chk("big_mem127", {32'd0, mem[127]}, {32'd0, stim[511], stim[510], stim[509], stim[508]});
        chk("big_error", {63'd0, error}, 64'd0);

        // Reset after 5 of 8 bytes abandons the load
        clear_mem();
        load_basic_stim();
        push_expected(2);
        begin_load(2);
        send_bytes(0, 5, 0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_hold", {63'd0, cpu_hold}, 64'd1);
        chk("midrst_ready", {63'd0, byte_ready}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        clear_mem();
        run_load(2, 0, 8);
        chk("reload_mem0", {32'd0, mem[0]}, 64'h0030_2203);
        chk("reload_mem1", {32'd0, mem[1]}, 64'h0010_2083);
        chk("reload_error", {63'd0, error}, 64'd0);
        chk("reload_wr_count", 64'(wr_pulses), 64'd2);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
